neokeon_round_constant_sequencer: RTL
=====================================

Name: neokeon_round_constant_sequencer

Overview:
Sequential round-constant source for the Neokeon core; the producer that feeds the state/constant XOR stage. Generates the 17 Neokeon round constants, forward for encryption and backward for decryption. Applies the current constant to a 128-bit state on request, with a registered output. Sits between the round controller and the state datapath, replacing hard-wired constants in the XOR stage.

Parameters:
NUM_ROUNDS, 16, number of full rounds; the sequence holds NUM_ROUNDS+1 constants, the last used by the output transform.
RC_FIRST_ENC, 8'h80, first encryption constant.
RC_FIRST_DEC, 8'hD4, first decryption constant (RC_FIRST_ENC stepped NUM_ROUNDS times).

Ports:
inClk  input  1  clock, rising edge
inRst  input  1  asynchronous active-high reset
inStart  input  1  begin a new sequence
inDecrypt  input  1  sampled with inStart: 0 = forward sequence, 1 = reverse sequence
inAdvance  input  1  apply the current constant to inDataState, then step the sequence
inDataState  input  128  state word a0..a3, with a0 in bits [127:96]
outDataState  output  128  registered inDataState with the constant XORed into a0
outValid  output  1  one-cycle pulse: outDataState updated
outConstant  output  32  current constant, {24'h0, rc}
outRound  output  5  index of the current constant, 0..NUM_ROUNDS
outLast  output  1  high while the current constant is the final one
outBusy  output  1  sequence in progress
outDone  output  1  one-cycle pulse after the final constant is consumed

Behaviour:
- Reset (asynchronous, any state, including mid-sequence):
  - State goes to IDLE.
  - rc = 0, outConstant = 0, outRound = 0, outDataState = 0.
  - outValid, outDone, outBusy, outLast = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + inStart:
  - Next cycle: RUN, rc = inDecrypt ? RC_FIRST_DEC : RC_FIRST_ENC, outRound = 0, outBusy = 1.
  - The direction bit is latched internally.
  - inAdvance in the same cycle is ignored.
- RUN + inStart: ignored. There is no restart mid-sequence; only reset aborts.
- RUN + inAdvance, one-cycle latency:
  - outDataState <= inDataState ^ {24'h0, rc, 96'h0}.
  - outValid = 1 for exactly one cycle.
  - rc steps; outRound increments.
- Forward step: rc' = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00).
- Reverse step:
  - rc[0] = 1: rc' = {1'b1, (rc ^ 8'h1B)[7:1]}.
  - rc[0] = 0: rc' = {1'b0, rc[7:1]}.
- Forward sequence: 80 1B 36 6C D8 AB 4D 9A 2F 5E BC 63 C6 97 35 6A D4. Reverse sequence is the exact reverse.
- outLast = (state == RUN) && (outRound == NUM_ROUNDS).
- inAdvance while outLast = 1:
  - State goes to DONE; outDone pulses with the final outValid.
  - outBusy = 0.
  - rc and outRound hold the final values; no wrap-around.
- inAdvance in IDLE or DONE: no effect; outValid stays 0 and outDataState holds.
- outDataState holds its value between advances.
- outConstant is combinational from the rc register; outRound is registered.
- Back-to-back inAdvance on every cycle is supported: 17 consecutive advances yield 17 outValid pulses.

Test Plan:
- Reset mid-sequence: assert inRst after 5 advances -> all outputs 0 immediately (asynchronous); a new inStart restarts at 80.
- Encrypt sequence: inStart with inDecrypt = 0, then 17 back-to-back advances -> outConstant steps through 0x80 … 0xD4; outLast high only at round 16; outDone pulses once; outBusy falls.
- Decrypt sequence: inDecrypt = 1 -> constants D4 6A 35 97 C6 63 … 1B 80, the exact reverse of the encrypt list.
- State XOR, encrypt round 0: inDataState = 2a78429b87c7d0924f26113f1d1349b2 -> outDataState = 2a78421b87c7d0924f26113f1d1349b2, outValid for 1 cycle.
- State XOR, decrypt round 0: same inDataState -> outDataState = 2a78424f87c7d0924f26113f1d1349b2.
- Guard cases:
  - inStart during RUN: ignored.
  - inAdvance in IDLE or DONE: no outValid.
  - inStart + inAdvance in the same cycle: only the start takes effect.
  - Gapped advances (1 every 3 cycles): same constant sequence.

Source files
------------

// File: rtl/neokeon_round_constant_sequencer_if.sv
// Handshake/data bundle between the Neokeon round controller and the
// round-constant sequencer.
//   master : round controller side (drives requests and state, sees results)
//   slave  : sequencer side
// Signals:
//   inStart/inDecrypt/inAdvance : sequence control
//   inDataState                 : 128-bit state word, a0 in [127:96]
//   outDataState/outValid       : registered state with constant applied
//   outConstant/outRound        : current constant and its index
//   outLast/outBusy/outDone     : sequence status
interface neokeon_round_constant_sequencer_if;
  logic         inStart;
  logic         inDecrypt;
  logic         inAdvance;
  logic [127:0] inDataState;
  logic [127:0] outDataState;
  logic         outValid;
  logic [31:0]  outConstant;
  logic [4:0]   outRound;
  logic         outLast;
  logic         outBusy;
  logic         outDone;

  modport master (
    output inStart, inDecrypt, inAdvance, inDataState,
    input  outDataState, outValid, outConstant, outRound, outLast, outBusy, outDone
  );

  modport slave (
    input  inStart, inDecrypt, inAdvance, inDataState,
    output outDataState, outValid, outConstant, outRound, outLast, outBusy, outDone
  );
endinterface

// File: rtl/neokeon_round_constant_sequencer.sv
// Neokeon round-constant sequencer. Produces the NUM_ROUNDS+1 round
// constants forward (encrypt) or backward (decrypt) and XORs the current
// constant into word a0 of the incoming state on each advance.
// Ports:
//   inClk : clock, rising edge
//   inRst : asynchronous active-high reset
//   bus   : slave side of neokeon_round_constant_sequencer_if
module neokeon_round_constant_sequencer #(
  parameter int unsigned NUM_ROUNDS   = 16,
  parameter logic [7:0]  RC_FIRST_ENC = 8'h80,
  parameter logic [7:0]  RC_FIRST_DEC = 8'hD4
) (
  input logic                                  inClk,
  input logic                                  inRst,
  neokeon_round_constant_sequencer_if.slave    bus
);

  localparam logic [4:0] LastRound = 5'(NUM_ROUNDS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [7:0]    rc_q, rc_d;
  logic [4:0]    round_q, round_d;
  logic          decrypt_q, decrypt_d;
  logic [127:0]  data_q, data_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          last;

  // Multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1.
  function automatic logic [7:0] step_fwd(input logic [7:0] rc);
    return {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
  endfunction

  // Inverse of step_fwd: an odd value must have come from a reduced shift.
  function automatic logic [7:0] step_rev(input logic [7:0] rc);
    logic [7:0] t;
    t = rc ^ 8'h1B;
    return rc[0] ? {1'b1, t[7:1]} : {1'b0, rc[7:1]};
  endfunction

  assign last = (state_q == StRun) && (round_q == LastRound);

  always_comb begin
    state_d   = state_q;
    rc_d      = rc_q;
    round_d   = round_q;
    decrypt_d = decrypt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        // A same-cycle advance is deliberately ignored here.
        if (bus.inStart) begin
          state_d   = StRun;
          rc_d      = bus.inDecrypt ? RC_FIRST_DEC : RC_FIRST_ENC;
          round_d   = 5'd0;
          decrypt_d = bus.inDecrypt;
        end
      end
      StRun: begin
        if (bus.inAdvance) begin
          data_d  = bus.inDataState ^ {24'h0, rc_q, 96'h0};
          valid_d = 1'b1;
          if (last) begin
            // Hold the final constant and index; no wrap-around.
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            rc_d    = decrypt_q ? step_rev(rc_q) : step_fwd(rc_q);
            round_d = round_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      state_q   <= StIdle;
      rc_q      <= 8'h00;
      round_q   <= 5'd0;
      decrypt_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rc_q      <= rc_d;
      round_q   <= round_d;
      decrypt_q <= decrypt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign bus.outDataState = data_q;
  assign bus.outValid     = valid_q;
  assign bus.outConstant  = {24'h0, rc_q};
  assign bus.outRound     = round_q;
  assign bus.outLast      = last;
  assign bus.outBusy      = (state_q == StRun);
  assign bus.outDone      = done_q;

endmodule
